mark_anim: RTL

Animated, parametrised X/O mark renderer for the XO game VGA pixel path. On a `start` pulse it latches a board-cell origin and reveals the mark stroke by stroke, advancing once per video frame. It answers "is this scan pixel part of the mark?" with a fixed two-cycle pipeline latency. One instance sits per board cell and feeds the pixel colour mux alongside the grid and square primitives.

---
 rtl/mark_pkg.sv | 24 ++
 rtl/mark_geom.sv | 70 +++++++
 rtl/mark_anim.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mark_pkg.sv
// Shared types and defaults for the animated X/O mark renderer.
// Ring support in mark_geom/mark_anim is compiled in with MARK_ANIM_RING_EN.
package mark_pkg;

    typedef enum logic [1:0] {
        MARK_IDLE    = 2'd0,
        MARK_STROKE1 = 2'd1,
        MARK_STROKE2 = 2'd2,
        MARK_DONE    = 2'd3
    } mark_state_e;

    typedef enum logic {
        MARK_CROSS = 1'b0,
        MARK_RING  = 1'b1
    } mark_mode_e;

    localparam int MARK_X_W = 10;
    localparam int MARK_Y_W = 9;

    function automatic int mark_ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/mark_geom.sv
// Combinational stroke hit test for one box-relative pixel offset.
// Ring (squared-distance) logic exists only when MARK_ANIM_RING_EN is defined.
module mark_geom
    import mark_pkg::*;
#(
    parameter int SIZE      = 103,
    parameter int THICKNESS = 7,
    parameter int X_W       = MARK_X_W,
    parameter int Y_W       = MARK_Y_W,
    parameter int LEN_W     = $clog2(SIZE + 1)
) (
    input  logic [X_W-1:0]   i_dx,
    input  logic [Y_W-1:0]   i_dy,
    input  logic [LEN_W-1:0] i_len1,
    input  logic [LEN_W-1:0] i_len2,
    input  mark_mode_e       i_mode,
    output logic             o_hit
);

    localparam int DW = ((X_W > Y_W) ? X_W : Y_W) + 2;

    logic        [DW-1:0] w_dx_u, w_dy_u, w_len1_u, w_len2_u;
    logic signed [DW-1:0] w_dx_s, w_dy_s, w_diag, w_anti, w_diag_abs, w_anti_abs;
    logic                 w_on_diag, w_on_anti, w_cross_hit;

    assign w_dx_u   = DW'(i_dx);
    assign w_dy_u   = DW'(i_dy);
    assign w_len1_u = DW'(i_len1);
    assign w_len2_u = DW'(i_len2);
    assign w_dx_s   = signed'(w_dx_u);
    assign w_dy_s   = signed'(w_dy_u);

    assign w_diag     = w_dx_s - w_dy_s;
    assign w_anti     = w_dx_s + w_dy_s - signed'(DW'(SIZE - 1));
    assign w_diag_abs = (w_diag < 0) ? -w_diag : w_diag;
    assign w_anti_abs = (w_anti < 0) ? -w_anti : w_anti;
    assign w_on_diag  = w_diag_abs < signed'(DW'(THICKNESS));
    assign w_on_anti  = w_anti_abs < signed'(DW'(THICKNESS));

    // Both strokes reveal left to right, so the gate is on dx for each.
    assign w_cross_hit = (w_on_diag && (w_dx_u < w_len1_u)) ||
                         (w_on_anti && (w_dx_u < w_len2_u));

`ifdef MARK_ANIM_RING_EN
    localparam int SW = 2 * X_W + 2;
    localparam int C  = (SIZE - 1) / 2;
    localparam logic [SW-1:0] R_IN  = SW'((C - THICKNESS) * (C - THICKNESS));
    localparam logic [SW-1:0] R_OUT = SW'(C * C);

    logic signed [DW-1:0] w_rx, w_ry, w_rx_abs, w_ry_abs;
    logic        [SW-1:0] w_ax, w_ay, w_d2;
    logic                 w_ring_hit;

    assign w_rx     = w_dx_s - signed'(DW'(C));
    assign w_ry     = w_dy_s - signed'(DW'(C));
    assign w_rx_abs = (w_rx < 0) ? -w_rx : w_rx;
    assign w_ry_abs = (w_ry < 0) ? -w_ry : w_ry;
    assign w_ax     = SW'(unsigned'(w_rx_abs));
    assign w_ay     = SW'(unsigned'(w_ry_abs));
    assign w_d2     = w_ax * w_ax + w_ay * w_ay;

    // Ring is wiped top-down by stroke 1's length.
    assign w_ring_hit = (w_d2 >= R_IN) && (w_d2 <= R_OUT) && (w_dy_u < w_len1_u);

    assign o_hit = (i_mode == MARK_RING) ? w_ring_hit : w_cross_hit;
`else
    assign o_hit = (i_mode == MARK_CROSS) && w_cross_hit;
`endif

endmodule

// File: rtl/mark_anim.sv
// Animated X/O mark: frame-stepped stroke reveal plus a 2-stage pixel hit pipeline.
// Ring mode is available only when MARK_ANIM_RING_EN is defined; otherwise always a cross.
module mark_anim
    import mark_pkg::*;
#(
    parameter int SIZE              = 103,
    parameter int THICKNESS         = 7,
    parameter int FRAMES_PER_STROKE = 16,
    parameter int X_W               = MARK_X_W,
    parameter int Y_W               = MARK_Y_W
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_frame_tick,
    input  logic           i_start,
    input  logic           i_clear,
    input  logic           i_mode,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic [X_W-1:0] i_scan_x,
    input  logic [Y_W-1:0] i_scan_y,
    output logic           o_draw,
    output logic           o_busy,
    output logic           o_done
);

    localparam int STEP  = mark_ceil_div(SIZE, FRAMES_PER_STROKE);
    localparam int LEN_W = $clog2(SIZE + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(SIZE);
    localparam logic [LEN_W:0]   STEP_EXT = (LEN_W + 1)'(STEP);
    localparam logic [LEN_W:0]   MAX_EXT  = (LEN_W + 1)'(SIZE);

    mark_state_e      r_state, w_state_nx;
    mark_mode_e       r_mode, w_mode_nx, w_mode_in;
    logic [LEN_W-1:0] r_len1, r_len2, w_len1_nx, w_len2_nx, w_len1_adv, w_len2_adv;
    logic [LEN_W:0]   w_sum1, w_sum2;
    logic [X_W-1:0]   r_ox, w_ox_nx;
    logic [Y_W-1:0]   r_oy, w_oy_nx;

`ifdef MARK_ANIM_RING_EN
    assign w_mode_in = mark_mode_e'(i_mode);
`else
    logic w_unused_mode;
    assign w_unused_mode = i_mode;
    assign w_mode_in     = MARK_CROSS;
`endif

    assign w_sum1     = {1'b0, r_len1} + STEP_EXT;
    assign w_sum2     = {1'b0, r_len2} + STEP_EXT;
    assign w_len1_adv = (w_sum1 >= MAX_EXT) ? LEN_MAX : w_sum1[LEN_W-1:0];
    assign w_len2_adv = (w_sum2 >= MAX_EXT) ? LEN_MAX : w_sum2[LEN_W-1:0];

    // Priority: clear > start > frame_tick.
    always_comb begin
        w_state_nx = r_state;
        w_mode_nx  = r_mode;
        w_len1_nx  = r_len1;
        w_len2_nx  = r_len2;
        w_ox_nx    = r_ox;
        w_oy_nx    = r_oy;
        if (i_clear) begin
            w_state_nx = MARK_IDLE;
            w_len1_nx  = '0;
            w_len2_nx  = '0;
        end else if (i_start) begin
            w_state_nx = MARK_STROKE1;
            w_len1_nx  = '0;
            w_len2_nx  = '0;
            w_ox_nx    = i_x;
            w_oy_nx    = i_y;
            w_mode_nx  = w_mode_in;
        end else if (i_frame_tick) begin
            case (r_state)
                MARK_STROKE1: begin
                    w_len1_nx = w_len1_adv;
                    if (w_len1_adv == LEN_MAX)
                        w_state_nx = (r_mode == MARK_RING) ? MARK_DONE : MARK_STROKE2;
                end
                MARK_STROKE2: begin
                    w_len2_nx = w_len2_adv;
                    if (w_len2_adv == LEN_MAX)
                        w_state_nx = MARK_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= MARK_IDLE;
            r_mode  <= MARK_CROSS;
            r_len1  <= '0;
            r_len2  <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_len1  <= w_len1_nx;
            r_len2  <= w_len2_nx;
            r_ox    <= w_ox_nx;
            r_oy    <= w_oy_nx;
        end
    end

    assign o_busy = (r_state == MARK_STROKE1) || (r_state == MARK_STROKE2);
    assign o_done = (r_state == MARK_DONE);

    // Stage 1: offsets wrap, so pixels left of / above the origin fail the box test.
    logic [X_W-1:0]   w_dx, r_s1_dx;
    logic [Y_W-1:0]   w_dy, r_s1_dy;
    logic             w_inbox, r_s1_inbox;
    mark_state_e      r_s1_state;
    mark_mode_e       r_s1_mode;
    logic [LEN_W-1:0] r_s1_len1, r_s1_len2;
    logic             w_hit, r_draw;

    assign w_dx    = i_scan_x - r_ox;
    assign w_dy    = i_scan_y - r_oy;
    assign w_inbox = (32'(w_dx) < 32'(SIZE)) && (32'(w_dy) < 32'(SIZE));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_dx    <= '0;
            r_s1_dy    <= '0;
            r_s1_inbox <= 1'b0;
            r_s1_state <= MARK_IDLE;
            r_s1_mode  <= MARK_CROSS;
            r_s1_len1  <= '0;
            r_s1_len2  <= '0;
            r_draw     <= 1'b0;
        end else begin
            r_s1_dx    <= w_dx;
            r_s1_dy    <= w_dy;
            r_s1_inbox <= w_inbox;
            r_s1_state <= r_state;
            r_s1_mode  <= r_mode;
            r_s1_len1  <= r_len1;
            r_s1_len2  <= r_len2;
            r_draw     <= r_s1_inbox && (r_s1_state != MARK_IDLE) && w_hit;
        end
    end

    mark_geom #(
        .SIZE      (SIZE),
        .THICKNESS (THICKNESS),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .LEN_W     (LEN_W)
    ) u_geom (
        .i_dx   (r_s1_dx),
        .i_dy   (r_s1_dy),
        .i_len1 (r_s1_len1),
        .i_len2 (r_s1_len2),
        .i_mode (r_s1_mode),
        .o_hit  (w_hit)
    );

    assign o_draw = r_draw;

endmodule
